// File: rtl/pbkdf2_hash_unloader_if.sv
// Word stream from the PBKDF2 hash unloader to its consumer
// (ROMix scratchpad loader or host readback path).
// master: the unloader (drives data/valid/last), slave: the consumer (drives ready).
interface pbkdf2_hash_unloader_if #(
   parameter int WORD_W = 32
);
   logic [WORD_W-1:0] out_data;
   logic              out_valid;
   logic              out_ready;
   logic              out_last;

   modport master (
      output out_data,
      output out_valid,
      output out_last,
      input  out_ready
   );

   modport slave (
      input  out_data,
      input  out_valid,
      input  out_last,
      output out_ready
   );
endinterface

// File: rtl/pbkdf2_hash_unloader.sv
// pbkdf2_hash_unloader
// Captures the wide derived key on the one-cycle hash_done pulse and streams it
// out little-endian by word (word 0 = hash[WORD_W-1:0]) over valid/ready.
// A hash_done arriving together with the final transfer is taken back-to-back;
// any other hash_done while streaming is dropped and sets the sticky overrun flag.
// Optional macro SCRYPT_WORD_BSWAP_EN: byte-reverse every output word for a
// big-endian host; ordering, handshake and timing are unaffected.
module pbkdf2_hash_unloader #(
   parameter int HASH_W = 1024,
   parameter int WORD_W = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [HASH_W-1:0]   hash,
   input  logic                hash_done,
   output logic                busy,
   output logic                overrun,
   pbkdf2_hash_unloader_if.master stream
);

   localparam int NW    = HASH_W / WORD_W;
   localparam int IDX_W = (NW > 1) ? $clog2(NW) : 1;

   localparam logic [0:0] ST_IDLE   = 1'b0;
   localparam logic [0:0] ST_STREAM = 1'b1;

   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NW - 1);

   logic [0:0]        state_reg,   state_next;
   logic [IDX_W-1:0]  idx_reg,     idx_next;
   logic [HASH_W-1:0] buffer_reg,  buffer_next;
   logic              overrun_reg, overrun_next;

   logic              streaming;
   logic              transfer;
   logic              at_last;
   logic [WORD_W-1:0] word_arr [NW];
   logic [WORD_W-1:0] word_sel;
   logic [WORD_W-1:0] word_out;

   assign streaming = (state_reg == ST_STREAM);
   assign transfer  = streaming && stream.out_ready;
   assign at_last   = (idx_reg == IDX_LAST);

   // View the captured buffer as an array of words for the index mux
   generate
      for (genvar gi = 0; gi < NW; gi++) begin : g_words
         assign word_arr[gi] = buffer_reg[gi*WORD_W +: WORD_W];
      end
   endgenerate

   assign word_sel = word_arr[idx_reg];

`ifdef SCRYPT_WORD_BSWAP_EN
   // Byte-reverse the selected word for the big-endian readback path
   generate
      for (genvar gi = 0; gi < WORD_W/8; gi++) begin : g_bswap
         assign word_out[gi*8 +: 8] = word_sel[WORD_W-8-gi*8 +: 8];
      end
   endgenerate
`else
   assign word_out = word_sel;
`endif

   // Next-state logic: capture, advance, back-to-back reload, overrun detection
   always_comb begin
      state_next   = state_reg;
      idx_next     = idx_reg;
      buffer_next  = buffer_reg;
      overrun_next = overrun_reg;
      case (state_reg)
         ST_IDLE: begin
            if (hash_done) begin
               buffer_next = hash;
               idx_next    = '0;
               state_next  = ST_STREAM;
            end
         end
         default: begin
            if (transfer && at_last) begin
               idx_next = '0;
               if (hash_done) begin
                  // Final word leaves as the next hash arrives: no bubble
                  buffer_next = hash;
               end else begin
                  state_next = ST_IDLE;
               end
            end else begin
               if (transfer) begin
                  idx_next = idx_reg + IDX_W'(1);
               end
               if (hash_done) begin
                  overrun_next = 1'b1;
               end
            end
         end
      endcase
   end

   // State registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg   <= ST_IDLE;
         idx_reg     <= '0;
         buffer_reg  <= '0;
         overrun_reg <= 1'b0;
      end else begin
         state_reg   <= state_next;
         idx_reg     <= idx_next;
         buffer_reg  <= buffer_next;
         overrun_reg <= overrun_next;
      end
   end

   // Outputs decode registers only; data is forced to zero outside a stream
   assign busy             = streaming;
   assign overrun          = overrun_reg;
   assign stream.out_valid = streaming;
   assign stream.out_last  = streaming && at_last;
   assign stream.out_data  = streaming ? word_out : '0;

endmodule

// File: tb/tb_pbkdf2_hash_unloader.sv
// Testbench for pbkdf2_hash_unloader: directed scenarios plus a random phase,
// checked against a queue-based model of the words still owed to the consumer.
module tb_pbkdf2_hash_unloader;

   localparam int HASH_W = 1024;
   localparam int WORD_W = 32;
   localparam int NW     = HASH_W / WORD_W;

   logic              clk = 1'b0;
   logic              rst;
   logic [HASH_W-1:0] hash;
   logic              hash_done;
   logic              busy;
   logic              overrun;

   pbkdf2_hash_unloader_if #(.WORD_W(WORD_W)) stream_if ();

   pbkdf2_hash_unloader #(.HASH_W(HASH_W), .WORD_W(WORD_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .hash      (hash),
      .hash_done (hash_done),
      .busy      (busy),
      .overrun   (overrun),
      .stream    (stream_if)
   );

   always #5 clk = ~clk;

   // Reference model: queue of words still to be delivered, sticky overrun
   logic [WORD_W-1:0] exp_q [$];
   logic              overrun_m;

   int pass_cnt  = 0;
   int total_cnt = 0;
   int xfer_cnt  = 0;

   function automatic logic [WORD_W-1:0] present(input logic [WORD_W-1:0] w);
`ifdef SCRYPT_WORD_BSWAP_EN
      return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
      return w;
`endif
   endfunction

   task automatic chk(input string tag, input logic [WORD_W-1:0] obs,
                      input logic [WORD_W-1:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   // One clock cycle: drive inputs, compare at negedge, advance model, pass the edge
   task automatic step(input logic rdy, input logic done, input logic [HASH_W-1:0] h);
      int n;
      logic xfer;
      stream_if.out_ready = rdy;
      hash_done           = done;
      hash                = h;
      @(negedge clk);
      n = exp_q.size();
      chk("valid",   {31'd0, stream_if.out_valid}, {31'd0, n > 0});
      chk("busy",    {31'd0, busy},                {31'd0, n > 0});
      chk("last",    {31'd0, stream_if.out_last},  {31'd0, n == 1});
      chk("overrun", {31'd0, overrun},             {31'd0, overrun_m});
      if (n > 0) chk("data", stream_if.out_data, exp_q[0]);
      xfer = (n > 0) && rdy;
      if (xfer) begin
         $display("xfer %0d data=%h last=%b", xfer_cnt, stream_if.out_data, stream_if.out_last);
         xfer_cnt++;
         void'(exp_q.pop_front());
      end
      if (done) begin
         if (n == 0 || (xfer && n == 1)) begin
            for (int k = 0; k < NW; k++) exp_q.push_back(present(h[k*WORD_W +: WORD_W]));
         end else begin
            overrun_m = 1'b1;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input logic done_during);
      rst                 = 1'b1;
      hash_done           = done_during;
      hash                = {NW{32'hdeadbeef}};
      stream_if.out_ready = 1'b1;
      @(posedge clk);
      #1;
      rst       = 1'b0;
      hash_done = 1'b0;
      exp_q.delete();
      overrun_m = 1'b0;
   endtask

   // Run until the model owes nothing; pattern 0 = ready high, 1 = 1,0,0,1, 2 = random
   task automatic drain(input int pattern);
      int i;
      logic r;
      i = 0;
      while (exp_q.size() > 0 && i < 400) begin
         case (pattern)
            0:       r = 1'b1;
            1:       r = (i % 4 == 0) || (i % 4 == 3);
            default: r = 1'($urandom_range(0, 1));
         endcase
         step(r, 1'b0, '0);
         i++;
      end
      chk("drain_bound", i, (i < 400) ? i : 0);
   endtask

   function automatic logic [HASH_W-1:0] idx_hash(input int base);
      logic [HASH_W-1:0] h;
      for (int k = 0; k < NW; k++) h[k*WORD_W +: WORD_W] = WORD_W'(k + base);
      return h;
   endfunction

   function automatic logic [HASH_W-1:0] rand_hash();
      logic [HASH_W-1:0] h;
      for (int k = 0; k < NW; k++) h[k*WORD_W +: WORD_W] = $urandom;
      return h;
   endfunction

   initial begin
      logic [HASH_W-1:0] h;
      int start;
      overrun_m = 1'b0;
      rst = 1'b1;
      hash = '0;
      hash_done = 1'b0;
      stream_if.out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      do_reset(1'b0);

      // Reset state
      chk("rst_data", stream_if.out_data, '0);
      step(1'b0, 1'b0, '0);

      // Basic stream: every byte 8'h01
      h = {(HASH_W/8){8'h01}};
      step(1'b1, 1'b1, h);
      start = xfer_cnt;
      chk("basic_word0", stream_if.out_data, 32'h01010101);
      drain(0);
      chk("basic_count", xfer_cnt - start, NW);
      step(1'b1, 1'b0, '0);

      // Word order: word k = k
      step(1'b1, 1'b1, idx_hash(0));
      step(1'b1, 1'b0, '0);
`ifdef SCRYPT_WORD_BSWAP_EN
      chk("order_word1", stream_if.out_data, 32'h01000000);
`else
      chk("order_word1", stream_if.out_data, 32'h00000001);
`endif
      drain(0);

      // Back-pressure 1,0,0,1
      start = xfer_cnt;
      step(1'b0, 1'b1, rand_hash());
      drain(1);
      chk("bp_count", xfer_cnt - start, NW);

      // Back-to-back: new hash with the final transfer
      step(1'b1, 1'b1, idx_hash(0));
      while (exp_q.size() > 1) step(1'b1, 1'b0, '0);
      step(1'b1, 1'b1, idx_hash(100));
      chk("b2b_word0", stream_if.out_data, present(32'd100));
      chk("b2b_overrun", {31'd0, overrun}, 32'd0);
      drain(0);

      // Overrun: drop a hash_done at idx 5
      step(1'b1, 1'b1, idx_hash(0));
      repeat (5) step(1'b1, 1'b0, '0);
      step(1'b0, 1'b1, idx_hash(500));
      chk("ovr_word5", stream_if.out_data, present(32'd5));
      drain(0);
      step(1'b0, 1'b0, '0);
      chk("ovr_sticky", {31'd0, overrun}, 32'd1);

      // Reset mid-stream at idx 10, hash_done during reset ignored
      step(1'b1, 1'b1, idx_hash(0));
      repeat (10) step(1'b1, 1'b0, '0);
      do_reset(1'b1);
      chk("mrst_valid",   {31'd0, stream_if.out_valid}, 32'd0);
      chk("mrst_busy",    {31'd0, busy},                32'd0);
      chk("mrst_overrun", {31'd0, overrun},             32'd0);
      step(1'b1, 1'b1, idx_hash(7));
      chk("mrst_word0", stream_if.out_data, present(32'd7));
      drain(0);

      // Random traffic
      for (int i = 0; i < 600; i++) begin
         step(1'($urandom_range(0, 3) != 0), ($urandom_range(0, 19) == 0), rand_hash());
      end
      drain(2);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
